// File: rtl/sprite_scheduler.sv
// rtl/sprite_scheduler.sv - shift/load sequencing for the circular sprite register
// Optional SPRITE_SCALE2_EN: horizontal 2x pixel doubling.
module sprite_scheduler #(
   parameter int WIDTH   = 10,
   parameter int HEIGHT  = 10,
   parameter int COORD_W = 10
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic               display_on,
   input  logic               frame_start,
   input  logic [COORD_W-1:0] sprite_x,
   input  logic [COORD_W-1:0] sprite_y,
   input  logic               sprite_en,
   input  logic               load_valid,
   input  logic               load_bit,
   output logic               load_ready,
   output logic               shiftf,
   output logic               load,
   output logic               data_in,
   input  logic               data_out,
   output logic               pixel_on,
   output logic               busy
);
   localparam int TOTAL = WIDTH * HEIGHT;
   localparam int CNT_W = $clog2(TOTAL);
`ifdef SPRITE_SCALE2_EN
   localparam int XSPAN = 2 * WIDTH;
`else
   localparam int XSPAN = WIDTH;
`endif
   localparam logic [COORD_W-1:0] X_LIM    = COORD_W'(XSPAN);
   localparam logic [COORD_W-1:0] Y_LIM    = COORD_W'(HEIGHT);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TOTAL - 1);

   typedef enum logic [1:0] {ST_DRAW, ST_REALIGN, ST_LOAD} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_shift_cnt;
   logic [COORD_W-1:0] r_sx;
   logic [COORD_W-1:0] r_sy;
   logic               r_en;
   logic               r_pixel_on;
   logic [COORD_W-1:0] w_dx;
   logic [COORD_W-1:0] w_dy;
   logic               w_in_win;
   logic               w_draw_shift;
   logic               w_cnt_last;
   logic               w_pixel_nxt;

   // Unsigned wrap makes anything left of / above the sprite compare huge.
   assign w_dx       = x - r_sx;
   assign w_dy       = y - r_sy;
   assign w_in_win   = display_on & r_en & (w_dx < X_LIM) & (w_dy < Y_LIM);
   assign w_cnt_last = (r_shift_cnt == CNT_LAST);
`ifdef SPRITE_SCALE2_EN
   assign w_draw_shift = w_in_win & w_dx[0];
`else
   assign w_draw_shift = w_in_win;
`endif

   always_comb begin
      w_state_nxt = r_state;
      shiftf      = 1'b0;
      load        = 1'b0;
      data_in     = 1'b0;
      load_ready  = 1'b0;
      w_pixel_nxt = 1'b0;
      case (r_state)
         ST_DRAW: begin
            shiftf      = w_draw_shift;
            w_pixel_nxt = w_in_win & data_out;
            if (frame_start) begin
               if (r_shift_cnt != '0) begin
                  w_state_nxt = ST_REALIGN;
               end else if (load_valid) begin
                  w_state_nxt = ST_LOAD;
               end
            end
         end
         ST_REALIGN: begin
            shiftf = 1'b1;
            if (w_cnt_last) begin
               w_state_nxt = load_valid ? ST_LOAD : ST_DRAW;
            end
         end
         ST_LOAD: begin
            // Drawing stays suppressed until the full bitmap has been rewritten.
            load_ready = 1'b1;
            if (load_valid) begin
               shiftf  = 1'b1;
               load    = 1'b1;
               data_in = load_bit;
               if (w_cnt_last) begin
                  w_state_nxt = ST_DRAW;
               end
            end
         end
         default: w_state_nxt = ST_DRAW;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_DRAW;
         r_shift_cnt <= '0;
         r_sx        <= '0;
         r_sy        <= '0;
         r_en        <= 1'b0;
         r_pixel_on  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pixel_on <= w_pixel_nxt;
         if (shiftf) begin
            r_shift_cnt <= w_cnt_last ? '0 : r_shift_cnt + 1'b1;
         end
         if (frame_start) begin
            r_sx <= sprite_x;
            r_sy <= sprite_y;
            r_en <= sprite_en;
         end
      end
   end

   assign pixel_on = r_pixel_on;
   assign busy     = (r_state != ST_DRAW);

endmodule

// File: tb/tb_sprite_scheduler.sv
// tb/tb_sprite_scheduler.sv - self-checking bench for sprite_scheduler
// Honours SPRITE_SCALE2_EN in its window model.
module tb_sprite_scheduler;
   localparam int W      = 10;
   localparam int H      = 10;
   localparam int TOTAL  = W * H;
   localparam int VIS_W  = 640;
   localparam int VIS_H  = 480;
`ifdef SPRITE_SCALE2_EN
   localparam int XSPAN  = 2 * W;
   localparam bit SCALE2 = 1'b1;
`else
   localparam int XSPAN  = W;
   localparam bit SCALE2 = 1'b0;
`endif
   localparam logic [TOTAL-1:0] DEFAULT_BMP = {
      10'b0011111100, 10'b0100000010, 10'b1000000001, 10'b1010010101, 10'b1000000001,
      10'b1010000101, 10'b1001111001, 10'b1000000001, 10'b0100000010, 10'b0011111100};

   logic       clk, reset_n;
   logic [9:0] x, y, sprite_x, sprite_y;
   logic       display_on, frame_start, sprite_en, load_valid, load_bit;
   logic       load_ready, shiftf, load, data_in, data_out, pixel_on, busy;

   sprite_scheduler #(.WIDTH(W), .HEIGHT(H), .COORD_W(10)) dut (
      .clk(clk), .reset_n(reset_n), .x(x), .y(y), .display_on(display_on),
      .frame_start(frame_start), .sprite_x(sprite_x), .sprite_y(sprite_y),
      .sprite_en(sprite_en), .load_valid(load_valid), .load_bit(load_bit),
      .load_ready(load_ready), .shiftf(shiftf), .load(load), .data_in(data_in),
      .data_out(data_out), .pixel_on(pixel_on), .busy(busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural sprite register: circular, insert at MSB, bit 0 visible.
   logic [TOTAL-1:0] sreg;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) sreg <= DEFAULT_BMP;
      else if (shiftf) sreg <= {(load ? data_in : sreg[0]), sreg[TOTAL-1:1]};
   end
   assign data_out = sreg[0];

   // Model: bitmap content, shifts since alignment, latched sprite placement.
   logic [TOTAL-1:0] exp_bmp;
   int               m_cnt;
   int               m_sx, m_sy;
   bit               m_en;
   int               checks, errors;
   int               dut_shifts, exp_shifts;
   logic [9:0]       row_log;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input int xv, input int yv, input bit de, input bit fs,
                        input bit lv, input bit lb);
      x = xv[9:0]; y = yv[9:0];
      display_on = de; frame_start = fs; load_valid = lv; load_bit = lb;
      #1;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic pulse_fs(input bit lv);
      drive(700, 490, 1'b0, 1'b1, lv, 1'b0);
      check("fs_shiftf", shiftf, 0);
      check("fs_load_ready", load_ready, 0);
      m_sx = int'(sprite_x); m_sy = int'(sprite_y); m_en = sprite_en;
      step();
   endtask

   task automatic sweep(input int ylo, input int yhi, input int xlo, input int xhi,
                        input bit suppressed);
      dut_shifts = 0; exp_shifts = 0;
      for (int yy = ylo; yy <= yhi; yy++) begin
         for (int xx = xlo; xx <= xhi; xx++) begin
            bit de, win, sh, pix;
            de  = (xx < VIS_W) && (yy < VIS_H);
            win = de && m_en && xx >= m_sx && xx < m_sx + XSPAN && yy >= m_sy && yy < m_sy + H;
            sh  = win && !suppressed && (!SCALE2 || ((xx - m_sx) % 2 == 1));
            pix = win && !suppressed && exp_bmp[m_cnt];
            drive(xx, yy, de, 1'b0, 1'b0, 1'b0);
            check("draw_shiftf", shiftf, sh);
            check("draw_load", load, 0);
            if (suppressed) check("stall_load_ready", load_ready, 1);
            if (shiftf) dut_shifts++;
            step();
            check("draw_pixel", pixel_on, pix);
            if (yy == 50 && xx >= 100 && xx < 110) row_log[xx-100] = pixel_on;
            if (sh) begin
               exp_shifts++;
               m_cnt = (m_cnt + 1) % TOTAL;
            end
         end
      end
      drive(700, 490, 1'b0, 1'b0, 1'b0, 1'b0);
      check("frame_shifts", dut_shifts, exp_shifts);
   endtask

   task automatic load_bits(input logic [TOTAL-1:0] bits, input int from, input int upto);
      for (int i = from; i < upto; i++) begin
         drive(700, 490, 1'b0, 1'b0, 1'b1, bits[i]);
         check("ld_ready", load_ready, 1);
         check("ld_shiftf", shiftf, 1);
         check("ld_load", load, 1);
         check("ld_data_in", data_in, bits[i]);
         check("ld_busy", busy, 1);
         step();
         m_cnt = (m_cnt + 1) % TOTAL;
      end
   endtask

   task automatic expect_load_done();
      drive(700, 490, 1'b0, 1'b0, 1'b1, 1'b1);
      check("ld_ready_drop", load_ready, 0);
      check("ld_no_shift", shiftf, 0);
      check("ld_busy_drop", busy, 0);
   endtask

   task automatic run_realign();
      int n, want;
      want = (TOTAL - m_cnt) % TOTAL;
      n = 0;
      for (int i = 0; i < 2 * TOTAL; i++) begin
         drive(700, 490, 1'b0, 1'b0, 1'b0, 1'b0);
         if (!busy) break;
         check("ra_shiftf", shiftf, 1);
         check("ra_load", load, 0);
         check("ra_pixel", pixel_on, 0);
         n++;
         step();
      end
      check("realign_len", n, want);
      check("realign_busy_end", busy, 0);
      m_cnt = (m_cnt + want) % TOTAL;
   endtask

   task automatic set_sprite(input int sx, input int sy, input bit en);
      sprite_x = sx[9:0]; sprite_y = sy[9:0]; sprite_en = en;
   endtask

   task automatic full_sweep(input bit suppressed);
      sweep(m_sy - 2, m_sy + H + 1, m_sx - 3, m_sx + XSPAN + 3, suppressed);
   endtask

   initial begin
      logic [TOTAL-1:0] bits;
      checks = 0; errors = 0; m_cnt = 0; m_sx = 0; m_sy = 0; m_en = 0;
      exp_bmp = DEFAULT_BMP; row_log = '0;
      reset_n = 1'b0;
      set_sprite(0, 0, 1'b0);
      drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(); step();
      check("rst_shiftf", shiftf, 0);
      check("rst_load", load, 0);
      check("rst_data_in", data_in, 0);
      check("rst_load_ready", load_ready, 0);
      check("rst_pixel_on", pixel_on, 0);
      check("rst_busy", busy, 0);
      reset_n = 1'b1;
      step();

      // Fully visible sprite, default bitmap.
      set_sprite(100, 50, 1'b1);
      pulse_fs(1'b0);
      drive(700, 490, 1'b0, 1'b0, 1'b0, 1'b0);
      check("fs_busy_idle", busy, 0);
      full_sweep(1'b0);
      check("full_shift_total", dut_shifts, 100);
`ifndef SPRITE_SCALE2_EN
      check("row50_pixels", row_log, 10'b0011111100);
`endif

      // Right-edge clipping, then realignment.
      set_sprite(635, 100, 1'b1);
      pulse_fs(1'b0);
      drive(700, 490, 1'b0, 1'b0, 1'b0, 1'b0);
      check("clip_fs_busy", busy, 0);
      full_sweep(1'b0);
`ifndef SPRITE_SCALE2_EN
      check("clip_shift_total", dut_shifts, 50);
`endif
      pulse_fs(1'b0);
      run_realign();

      // All-ones load in vblank, then draw it.
      bits = '1;
      pulse_fs(1'b1);
      load_bits(bits, 0, TOTAL);
      expect_load_done();
      exp_bmp = bits;
      set_sprite(300, 200, 1'b1);
      pulse_fs(1'b0);
      full_sweep(1'b0);

      // Random load stalled after 40 bits across an active frame.
      for (int i = 0; i < TOTAL; i++) bits[i] = 1'($urandom_range(0, 1));
      pulse_fs(1'b1);
      load_bits(bits, 0, 40);
      for (int i = 0; i < 5; i++) begin
         drive(700, 490, 1'b0, 1'b0, 1'b0, 1'b0);
         check("stall_idle_ready", load_ready, 1);
         check("stall_idle_shift", shiftf, 0);
         step();
      end
      full_sweep(1'b1);
      load_bits(bits, 40, TOTAL);
      expect_load_done();
      exp_bmp = bits;
      pulse_fs(1'b0);
      drive(700, 490, 1'b0, 1'b0, 1'b0, 1'b0);
      check("post_load_busy", busy, 0);
      full_sweep(1'b0);

      // Mid-frame position change takes effect only at the next frame_start.
      set_sprite(100, 50, 1'b1);
      pulse_fs(1'b0);
      sweep(48, 54, 96, 96 + 100 + XSPAN + 6, 1'b0);
      set_sprite(200, 50, 1'b1);
      sweep(55, 61, 96, 96 + 100 + XSPAN + 6, 1'b0);
      check("midframe_cnt_aligned", busy, 0);
      pulse_fs(1'b0);
      sweep(48, 61, 96, 96 + 100 + XSPAN + 6, 1'b0);
      check("moved_shift_total", dut_shifts, 100);

      // Random placements.
      for (int k = 0; k < 3; k++) begin
         set_sprite($urandom_range(4, VIS_W - XSPAN - 1), $urandom_range(2, VIS_H - H - 1), 1'b1);
         pulse_fs(1'b0);
         full_sweep(1'b0);
      end

      // Asynchronous reset in the middle of a drawn sprite.
      set_sprite(100, 50, 1'b1);
      pulse_fs(1'b0);
      sweep(48, 53, 96, 96 + XSPAN + 6, 1'b0);
      drive(100 + XSPAN - 1, 54, 1'b1, 1'b0, 1'b0, 1'b0);
      check("pre_reset_shiftf", shiftf, 1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_shiftf", shiftf, 0);
      check("mid_rst_pixel_on", pixel_on, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_load_ready", load_ready, 0);
      check("mid_rst_data_out", data_out, DEFAULT_BMP[0]);
      exp_bmp = DEFAULT_BMP; m_cnt = 0; m_en = 0;
      step(); step();
      check("mid_rst_pixel_hold", pixel_on, 0);
      reset_n = 1'b1;
      step();
      row_log = '1;
      pulse_fs(1'b0);
      full_sweep(1'b0);
      check("post_rst_first_pixel", row_log[0], 0);
      check("post_rst_shift_total", dut_shifts, 100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout: observed no completion expected $finish");
      $fatal(1, "timeout");
   end
endmodule
